// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator and its test-pattern source.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_CHECK = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_BLACK = 2'd3
    } pattern_e;

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black ({r,g,b}).
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern colour for one pixel; the caller registers and blanks it.
module video_pattern_gen
    import video_timing_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] bar_idx,
    input  logic [7:0] frame_cnt,
    input  pattern_e   pattern,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        unique case (pattern)
            PAT_CHECK: begin
                if (x[3] ^ y[3]) begin
                    {r, g, b} = 24'hFFFFFF;
                end
            end
            PAT_BARS:  {r, g, b} = BAR_RGB[bar_idx];
            PAT_GRAD: begin
                r = x;
                g = y;
                b = frame_cnt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: stage 1 holds the h/v counters, stage 2 registers
// every output from the stage-1 position so sync, DE, coordinates and RGB stay aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 5,
    parameter int H_SYNC   = 29,
    parameter int H_BP     = 94,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 17,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [1:0]       pattern_sel,
    output logic             hs,
    output logic             vs,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             field,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Stage 1 state
    logic [CNT_W-1:0] h_reg, v_reg, bar_sub_reg;
    logic [2:0]       bar_idx_reg;
    logic             field_reg;
    logic [7:0]       frame_cnt_reg;
    pattern_e         pat_reg;

    // Stage 2 output registers
    logic             hs_reg, vs_reg, hblank_reg, vblank_reg, de_reg;
    logic [CNT_W-1:0] x_reg, y_reg;
    logic             frame_start_reg, field_out_reg;
    logic [7:0]       r_reg, g_reg, b_reg;

    logic             h_wrap, v_wrap, at_origin, h_act, v_act, de_next;
    logic [CNT_W-1:0] x_next, y_next;
    logic [7:0]       r_next, g_next, b_next;
    pattern_e         pat_next;

    assign h_wrap    = (h_reg == H_LAST);
    assign v_wrap    = (v_reg == V_LAST);
    assign at_origin = (h_reg == '0) && (v_reg == '0);
    assign h_act     = (h_reg < H_ACT);
    assign v_act     = (v_reg < V_ACT);
    assign de_next   = h_act && v_act;
    assign x_next    = de_next ? h_reg : '0;
    assign y_next    = de_next ? v_reg : '0;
    // A selection arriving on the origin ce already applies to that first pixel.
    assign pat_next  = at_origin ? pattern_e'(pattern_sel) : pat_reg;

    video_pattern_gen u_pattern (
        .x         (x_next[7:0]),
        .y         (y_next[7:0]),
        .bar_idx   (bar_idx_reg),
        .frame_cnt (frame_cnt_reg),
        .pattern   (pat_next),
        .r         (r_next),
        .g         (g_next),
        .b         (b_next)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_reg         <= '0;
            v_reg         <= '0;
            bar_sub_reg   <= '0;
            bar_idx_reg   <= '0;
            field_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            pat_reg       <= PAT_CHECK;
        end else if (ce_pix) begin
            h_reg <= h_wrap ? '0 : h_reg + CNT_ONE;
            if (h_wrap) begin
                v_reg <= v_wrap ? '0 : v_reg + CNT_ONE;
                if (v_wrap) begin
                    field_reg     <= ~field_reg;
                    frame_cnt_reg <= frame_cnt_reg + 8'd1;
                end
            end
            // Bar index steps every H_ACTIVE/8 active pixels without a divider.
            if (h_wrap) begin
                bar_sub_reg <= '0;
                bar_idx_reg <= '0;
            end else if (h_act) begin
                if (bar_sub_reg == BAR_LAST) begin
                    bar_sub_reg <= '0;
                    bar_idx_reg <= bar_idx_reg + 3'd1;
                end else begin
                    bar_sub_reg <= bar_sub_reg + CNT_ONE;
                end
            end
            if (at_origin) begin
                pat_reg <= pat_next;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_reg          <= ~HS_POL;
            vs_reg          <= ~VS_POL;
            hblank_reg      <= 1'b1;
            vblank_reg      <= 1'b1;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            field_out_reg   <= 1'b0;
            r_reg           <= '0;
            g_reg           <= '0;
            b_reg           <= '0;
        end else if (ce_pix) begin
            hs_reg          <= (h_reg >= HS_BEG && h_reg < HS_END) ? HS_POL : ~HS_POL;
            vs_reg          <= (v_reg >= VS_BEG && v_reg < VS_END) ? VS_POL : ~VS_POL;
            hblank_reg      <= ~h_act;
            vblank_reg      <= ~v_act;
            de_reg          <= de_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            frame_start_reg <= at_origin;
            field_out_reg   <= field_reg;
            r_reg           <= de_next ? r_next : 8'd0;
            g_reg           <= de_next ? g_next : 8'd0;
            b_reg           <= de_next ? b_next : 8'd0;
        end
    end

    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign hblank      = hblank_reg;
    assign vblank      = vblank_reg;
    assign de          = de_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign frame_start = frame_start_reg;
    assign field       = field_out_reg;
    assign r           = r_reg;
    assign g           = g_reg;
    assign b           = b_reg;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator with a built-in test-pattern source, the next generation of the fixed 256x224 scanner used by the tutorial cores. It produces sync, blanking, DE, pixel coordinates and an RGB888 test pattern from a single pixel clock, with all geometry and sync polarities set by parameters. It sits between the core's pixel clock domain and the MiSTer video output path. Pattern selection is latched per frame, so switching never tears.

## Interface
Parameters:
- H_ACTIVE, 256, visible pixels per line; must be a multiple of 8
- H_FP, 5, front-porch pixels; ≥1
- H_SYNC, 29, hsync width in pixels; ≥1
- H_BP, 94, back-porch pixels; ≥1
- V_ACTIVE, 224, visible lines
- V_FP, 17, front-porch lines; ≥1
- V_SYNC, 3, vsync width in lines; ≥1
- V_BP, 20, back-porch lines; ≥1
- HS_POL, 0, active level of hs
- VS_POL, 0, active level of vs
- CNT_W, 10, counter width; must satisfy 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  pixel enable; state advances only when high
- pattern_sel  in  2  0 checkerboard, 1 colour bars, 2 gradient, 3 black
- hs  out  1  horizontal sync at HS_POL
- vs  out  1  vertical sync at VS_POL
- hblank  out  1  horizontal blanking
- vblank  out  1  vertical blanking
- de  out  1  ~(hblank|vblank)
- x  out  CNT_W  active pixel column; 0 outside active region
- y  out  CNT_W  active line; 0 outside active region
- frame_start  out  1  one-ce pulse at position (0,0)
- field  out  1  toggles every frame
- r, g, b  out  8 each  pattern colour; 0 when de=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Line order: active [0, H_ACTIVE), front porch, sync, back porch. Vertical order is the same.
- The h counter wraps from H_TOTAL-1 to 0.
- The v counter increments on the h wrap and wraps from V_TOTAL-1 to 0.
- hs is active while h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs uses the same rule on the v counter and is aligned to h=0.
- hblank=1 iff h≥H_ACTIVE. vblank=1 iff v≥V_ACTIVE.
- field and an 8-bit frame counter increment when v wraps.
- pattern_sel is sampled into the active pattern register only on the ce at counter position (0,0). Any other change is ignored until the next frame.
- Checkerboard: white if x[3]^y[3], else black.
- Colour bars: the bar index 0..7 advances every H_ACTIVE/8 pixels. Implement with a sub-counter; no divider.
  - r = {8{~idx[1]}}, g = {8{~idx[2]}}, b = {8{~idx[0]}}.
  - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
- Gradient: r = x[7:0], g = y[7:0], b = frame counter.
- Black: r = g = b = 0.

## Timing
- Pipeline stage 1 is the h/v counters. Stage 2 is all outputs, registered together.
- Outputs therefore lag the counters by exactly one ce. Sync, DE, coordinates and RGB are always mutually aligned.
- ce_pix=0 holds every register, including outputs. Pulses such as frame_start therefore last one ce, not one pclk.
- Reset values:
  - counters 0
  - hs=~HS_POL, vs=~VS_POL
  - hblank=vblank=1, de=0
  - x=y=0, r=g=b=0
  - frame_start=0, field=0, frame counter 0
  - active pattern 0
- On the first ce after reset release, outputs show position (0,0): de=1, frame_start=1.
- Reset asserted mid-frame returns everything to the reset values immediately (asynchronously). No partial-line recovery.
- A pattern_sel change on the same ce as (0,0) takes effect in that frame's first pixel output.

## Structure
- Package video_timing_pkg holds:
  - pattern-select constants (PAT_CHECK, PAT_BARS, PAT_GRAD, PAT_BLACK)
  - the 8-entry bar colour table
- Sub-module video_pattern_gen: combinational colour from (x, y, bar idx, frame counter, pattern). It feeds the stage-2 RGB register.
- The top holds the counters, the bar sub-counter, the pattern latch and the output registers.

## Test plan
Small geometry used below: H 16/2/3/3 (H_TOTAL 24), V 8/1/2/1 (V_TOTAL 12).
- Reset, ce_pix=1 constant, small geometry:
  - hs low for exactly 3 of every 24 clocks, starting 18 clocks after the line's first de.
  - vs low for 2 lines.
  - de high for 16×8 per 288 clocks.
- ce_pix toggling 1-0-1-0:
  - every output changes only on ce cycles.
  - frame_start is high for one ce (two pclk).
  - frame period is 576 pclk.
- pattern_sel=1, small geometry: each line shows exactly two pixels per bar, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- pattern_sel switched 0→2 mid-frame: the checkerboard continues to frame end. Next frame, pixel (5,3) reads r=05, g=03, b=frame count.
- Reset asserted at v=4, h=10 for one pclk:
  - outputs return to reset values asynchronously.
  - after release, the first ce shows frame_start=1, x=y=0, field=0.
- Default parameters, 2 frames:
  - H_TOTAL 384, V_TOTAL 264.
  - field toggles at each frame_start.
  - x never exceeds 255, y never exceeds 223.
